// File: rtl/wb_arbiter_2m_if.sv
// wb_arbiter_2m_if: bus bundle between two Wishbone masters, the arbiter and one slave.
// The arbiter connects through the slave modport; the surrounding masters/slave model use master.
interface wb_arbiter_2m_if;
    logic [1:0]  m_cyc_i;
    logic [1:0]  m_stb_i;
    logic [1:0]  m_we_i;
    logic [63:0] m_adr_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_dat_i;
    logic [5:0]  m_cti_i;
    logic [3:0]  m_bte_i;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_err_o;
    logic [1:0]  m_rty_o;
    logic [63:0] m_dat_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_ack_i;
    logic        s_err_i;
    logic        s_rty_i;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
        input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
        output m_ack_o, m_err_o, m_rty_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o,
        output gnt_o, timeout_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
        output s_ack_i, s_err_i, s_rty_i, s_dat_i,
        input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o,
        input  gnt_o, timeout_o
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin two-master Wishbone B3 arbiter with cycle lock and a stall watchdog.
module wb_arbiter_2m #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input logic            clk,
    input logic            rst,
    wb_arbiter_2m_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             g0, g1, granted, stb_g, term, timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Ownership is held for the whole cyc period; release always passes through IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE:    state_d = &bus.m_cyc_i ? (last_q ? GNT0 : GNT1) :
                               bus.m_cyc_i[0] ? GNT0 : bus.m_cyc_i[1] ? GNT1 : IDLE;
            GNT0:    if (!bus.m_cyc_i[0]) begin
                         state_d = IDLE;
                         last_d  = 1'b0;
                     end
            GNT1:    if (!bus.m_cyc_i[1]) begin
                         state_d = IDLE;
                         last_d  = 1'b1;
                     end
            default: state_d = IDLE;
        endcase
    end

    assign g0      = state_q == GNT0;
    assign g1      = state_q == GNT1;
    assign granted = g0 | g1;
    assign term    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    assign stb_g   = granted & (g1 ? bus.m_stb_i[1] : bus.m_stb_i[0]);
    // A slave termination in the expiry cycle beats the watchdog.
    assign timeout = stb_g & ~term & (wdog_q == CNT_W'(TIMEOUT - 1));
    assign wdog_d  = (stb_g & ~term & ~timeout) ? wdog_q + 1'b1 : '0;

    assign bus.s_cyc_o   = granted & (g1 ? bus.m_cyc_i[1] : bus.m_cyc_i[0]);
    assign bus.s_stb_o   = stb_g & ~timeout;
    assign bus.s_we_o    = granted & (g1 ? bus.m_we_i[1] : bus.m_we_i[0]);
    assign bus.s_adr_o   = g1 ? bus.m_adr_i[63:32] : g0 ? bus.m_adr_i[31:0] : '0;
    assign bus.s_sel_o   = g1 ? bus.m_sel_i[7:4]   : g0 ? bus.m_sel_i[3:0]  : '0;
    assign bus.s_dat_o   = g1 ? bus.m_dat_i[63:32] : g0 ? bus.m_dat_i[31:0] : '0;
    assign bus.s_cti_o   = g1 ? bus.m_cti_i[5:3]   : g0 ? bus.m_cti_i[2:0]  : '0;
    assign bus.s_bte_o   = g1 ? bus.m_bte_i[3:2]   : g0 ? bus.m_bte_i[1:0]  : '0;
    assign bus.m_ack_o   = {g1, g0} & {2{bus.s_ack_i}};
    assign bus.m_rty_o   = {g1, g0} & {2{bus.s_rty_i}};
    assign bus.m_err_o   = {g1, g0} & {2{bus.s_err_i | timeout}};
    assign bus.m_dat_o   = {2{bus.s_dat_i}};
    assign bus.gnt_o     = {g1, g0};
    assign bus.timeout_o = timeout;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed corner cases plus randomized two-master traffic against a slave model,
// with a transaction scoreboard whose expectations follow from each request's address.
module tb_wb_arbiter_2m;
    localparam int TO = 8;

    typedef struct packed {
        logic [1:0]  kind;
        logic        we;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mcyc[2], mstb[2], mwe[2];
    logic [31:0] madr[2], mdat[2];
    logic [3:0]  msel[2];
    logic [2:0]  mcti[2];
    logic [1:0]  mbte[2];
    logic        sack, serr, srty;
    logic [31:0] sdat;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    bit          rand_done = 0;
    exp_t        q0[$], q1[$];

    always #5 clk = ~clk;

    wb_arbiter_2m_if bus();

    wb_arbiter_2m #(.TIMEOUT(TO), .CNT_W(9)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.m_cyc_i = {mcyc[1], mcyc[0]};
    assign bus.m_stb_i = {mstb[1], mstb[0]};
    assign bus.m_we_i  = {mwe[1], mwe[0]};
    assign bus.m_adr_i = {madr[1], madr[0]};
    assign bus.m_sel_i = {msel[1], msel[0]};
    assign bus.m_dat_i = {mdat[1], mdat[0]};
    assign bus.m_cti_i = {mcti[1], mcti[0]};
    assign bus.m_bte_i = {mbte[1], mbte[0]};
    assign bus.s_ack_i = sack;
    assign bus.s_err_i = serr;
    assign bus.s_rty_i = srty;
    assign bus.s_dat_i = sdat;

    function automatic logic [31:0] rdat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] wdat(input logic [31:0] a);
        return ~a ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [3:0] sel4(input logic [31:0] a);
        return a[9:6];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            mcyc[k] = 0; mstb[k] = 0; mwe[k] = 0; madr[k] = '0;
            mdat[k] = '0; msel[k] = '0; mcti[k] = '0; mbte[k] = '0;
        end
        sack = 0; serr = 0; srty = 0; sdat = '0;
    endtask

    task automatic req(input int k, input logic [31:0] a, input logic we, input logic [2:0] cti);
        mcyc[k] = 1; mstb[k] = 1; mwe[k] = we; madr[k] = a;
        mdat[k] = wdat(a); msel[k] = sel4(a); mcti[k] = cti; mbte[k] = 2'b01;
    endtask

    task automatic drop(input int k);
        mcyc[k] = 0;
        mstb[k] = 0;
    endtask

    // Scoreboard monitor: every termination seen by a master retires its oldest expected request.
    task automatic monitor();
        exp_t       e;
        logic [1:0] kind;
        bit         empty;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) begin
                    if (bus.m_ack_o[k] | bus.m_err_o[k] | bus.m_rty_o[k]) begin
                        kind  = bus.m_ack_o[k] ? 2'd0 : bus.m_rty_o[k] ? 2'd1 : bus.timeout_o ? 2'd3 : 2'd2;
                        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                        if (empty) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_term m%0d: got kind %0d expected none", k, kind);
                        end else begin
                            e = (k == 0) ? q0.pop_front() : q1.pop_front();
                            check($sformatf("term_kind_m%0d", k), 64'(kind), 64'(e.kind));
                            if (kind == 2'd0 && !e.we)
                                check($sformatf("rdata_m%0d", k), 64'(bus.m_dat_o[32*k +: 32]), 64'(e.dat));
                        end
                    end
                end
            end
        end
    endtask

    // Address encodes the slave behaviour: [5:4] 0 ack, 1 rty, 2 err, 3 dead; [3:2] wait states.
    task automatic run_master(input int k, input int n);
        logic [31:0] a;
        exp_t        e;
        int          w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            tick();
            a = {k[0], 29'($urandom), 2'b00};
            e.kind = a[5:4];
            e.we   = 1'($urandom);
            e.dat  = rdat(a);
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
            req(k, a, e.we, 3'b000);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!(bus.m_ack_o[k] | bus.m_err_o[k] | bus.m_rty_o[k]) && w < 300);
            if (!(bus.m_ack_o[k] | bus.m_err_o[k] | bus.m_rty_o[k])) begin
                checks++;
                errors++;
                $display("FAIL m%0d_wait: got no termination after %0d cycles expected one", k, w);
            end
            tick();
            drop(k);
        end
    endtask

    task automatic run_slave();
        int          cnt = 0;
        logic        act;
        logic [31:0] a;
        while (!rand_done) begin
            @(posedge clk);
            #2;
            act = bus.s_cyc_o & bus.s_stb_o;
            a   = bus.s_adr_o;
            sack = 0; serr = 0; srty = 0;
            if (act) begin
                if (a[5:4] != 2'd3 && cnt == int'(a[3:2])) begin
                    sack = a[5:4] == 2'd0;
                    srty = a[5:4] == 2'd1;
                    serr = a[5:4] == 2'd2;
                    sdat = rdat(a);
                    check("slave_sel", 64'(bus.s_sel_o), 64'(sel4(a)));
                    if (bus.s_we_o) check("slave_wdata", 64'(bus.s_dat_o), 64'(wdat(a)));
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
        sack = 0; serr = 0; srty = 0;
    endtask

    initial begin
        rst = 0;
        idle_all();
        sack = 1; serr = 1; srty = 1;
        req(0, 32'h0000_0010, 0, 3'b000);
        req(1, 32'h0000_0020, 0, 3'b000);
        fork
            monitor();
        join_none
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", 64'(bus.gnt_o), 64'd0);
            check("rst_scyc", 64'(bus.s_cyc_o), 64'd0);
            check("rst_term", 64'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o, bus.timeout_o}), 64'd0);
        end
        tick(); rst = 1; idle_all();
        // Tie after reset: master 0 first, then master 1 after one turnaround cycle.
        tick(); req(0, 32'h0000_0100, 0, 3'b000); req(1, 32'h0000_0200, 0, 3'b000);
        @(negedge clk); check("tie_c0_gnt", 64'(bus.gnt_o), 64'd0);
        tick(); sack = 1; sdat = 32'hCAFE_0001;
        @(negedge clk);
        check("tie_c1_gnt", 64'(bus.gnt_o), 64'b01);
        check("tie_c1_ack", 64'(bus.m_ack_o), 64'b01);
        check("tie_c1_adr", 64'(bus.s_adr_o), 64'h100);
        check("tie_c1_dat", bus.m_dat_o, 64'hCAFE_0001_CAFE_0001);
        tick(); drop(0); sack = 0;
        @(negedge clk);
        check("tie_c2_gnt", 64'(bus.gnt_o), 64'b01);
        check("tie_c2_scyc", 64'(bus.s_cyc_o), 64'd0);
        tick(); @(negedge clk); check("tie_c3_gnt", 64'(bus.gnt_o), 64'd0);
        tick(); sack = 1;
        @(negedge clk);
        check("tie_c4_gnt", 64'(bus.gnt_o), 64'b10);
        check("tie_c4_ack", 64'(bus.m_ack_o), 64'b10);
        check("tie_c4_adr", 64'(bus.s_adr_o), 64'h200);
        tick(); drop(1); sack = 0;
        tick(); @(negedge clk); check("tie_end_gnt", 64'(bus.gnt_o), 64'd0);
        // Burst lock: master 0 arrives mid-burst and must wait for the whole cycle.
        tick(); req(1, 32'h0000_1000, 0, 3'b010);
        for (int b = 0; b < 4; b++) begin
            tick();
            madr[1] = 32'h0000_1000 + 32'(4 * b);
            mcti[1] = (b == 3) ? 3'b111 : 3'b010;
            sack = 1;
            if (b == 1) req(0, 32'h0000_0300, 1, 3'b000);
            @(negedge clk);
            check("burst_gnt", 64'(bus.gnt_o), 64'b10);
            check("burst_ack", 64'(bus.m_ack_o), 64'b10);
            check("burst_adr", 64'(bus.s_adr_o), 64'(32'h0000_1000 + 32'(4 * b)));
            check("burst_cti", 64'(bus.s_cti_o), 64'((b == 3) ? 3'b111 : 3'b010));
            check("burst_bte", 64'(bus.s_bte_o), 64'b01);
        end
        tick(); drop(1); sack = 0;
        @(negedge clk);
        check("burst_end_gnt", 64'(bus.gnt_o), 64'b10);
        check("burst_end_ack", 64'(bus.m_ack_o), 64'd0);
        tick(); @(negedge clk); check("burst_turn_gnt", 64'(bus.gnt_o), 64'd0);
        tick(); sack = 1;
        @(negedge clk);
        check("burst_m0_gnt", 64'(bus.gnt_o), 64'b01);
        check("burst_m0_ack", 64'(bus.m_ack_o), 64'b01);
        check("burst_m0_adr", 64'(bus.s_adr_o), 64'h300);
        check("burst_m0_we", 64'(bus.s_we_o), 64'd1);
        check("burst_m0_wdat", 64'(bus.s_dat_o), 64'(wdat(32'h300)));
        tick(); drop(0); sack = 0;
        tick(); tick();
        // Watchdog with a silent slave.
        tick(); req(0, 32'h0000_0400, 0, 3'b000);
        for (int c = 1; c <= TO; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("wd_c%0d_timeout", c), 64'(bus.timeout_o), 64'(c == TO));
            check($sformatf("wd_c%0d_err", c), 64'(bus.m_err_o), (c == TO) ? 64'b01 : 64'd0);
            check($sformatf("wd_c%0d_stb", c), 64'(bus.s_stb_o), 64'(c != TO));
        end
        tick(); @(negedge clk);
        check("wd_after_stb", 64'(bus.s_stb_o), 64'd1);
        check("wd_after_timeout", 64'(bus.timeout_o), 64'd0);
        tick(); drop(0);
        tick(); tick();
        // Slave ack lands exactly on the expiry cycle.
        tick(); req(0, 32'h0000_0500, 0, 3'b000);
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == TO) sack = 1;
            @(negedge clk);
            if (c == TO) begin
                check("race_ack", 64'(bus.m_ack_o), 64'b01);
                check("race_timeout", 64'(bus.timeout_o), 64'd0);
                check("race_err", 64'(bus.m_err_o), 64'd0);
            end else check($sformatf("race_c%0d_timeout", c), 64'(bus.timeout_o), 64'd0);
        end
        tick(); drop(0); sack = 0;
        tick(); tick();
        // Reset while master 1 waits; afterwards master 0 wins the tie again.
        tick(); req(1, 32'h0000_0600, 0, 3'b000); req(0, 32'h0000_0700, 0, 3'b000);
        tick(); @(negedge clk); check("mid_gnt", 64'(bus.gnt_o), 64'b10);
        tick(); tick(); rst = 0;
        tick(); rst = 1; sack = 1;
        @(negedge clk);
        check("mid_rst_gnt", 64'(bus.gnt_o), 64'd0);
        check("mid_rst_ack", 64'(bus.m_ack_o), 64'd0);
        tick(); sack = 0;
        @(negedge clk); check("mid_after_gnt", 64'(bus.gnt_o), 64'b01);
        tick(); drop(0); drop(1);
        tick(); tick(); tick();
        idle_all();
        mon_en = 1;
        fork
            begin
                fork
                    run_master(0, 60);
                    run_master(1, 60);
                join
                rand_done = 1;
            end
            run_slave();
        join
        repeat (2) @(negedge clk);
        mon_en = 0;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
